// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   UART transmitter that drains a first-word-fall-through FIFO. When the FIFO
//   has a word, it is popped and captured in the same cycle. The frame is then
//   shifted out as: start bit, D_SIZE data bits LSB first, an optional parity
//   bit, and a stop bit. If another word is waiting in the final stop-bit cycle,
//   it is captured at once, so frames run back to back with no idle cycle.
//
// Parameters
//   D_SIZE   : data word width (matches the FIFO read-data width)
//   PS_SIZE  : PRESCALE input width
//
// Ports
//   CLK      in   operating clock (FIFO read-domain clock)
//   RST      in   asynchronous, active-high reset
//   EMPTY    in   FIFO empty flag; 0 means RD_DATA is a valid head word
//   RD_DATA  in   FIFO head word (first-word-fall-through)
//   PAR_EN   in   1 = insert a parity bit after the data bits
//   PAR_TYP  in   0 = even parity, 1 = odd parity
//   PRESCALE in   CLK cycles per serial bit; 0 is treated as 1
//   R_INC    out  FIFO pop strobe, one cycle per word
//   TX_OUT   out  serial line, idle high (registered)
//   BUSY     out  high while a frame is on the line (registered)
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int D_SIZE  = 8,
    parameter int PS_SIZE = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EMPTY,
    input  logic [D_SIZE-1:0]  RD_DATA,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PS_SIZE-1:0] PRESCALE,
    output logic               R_INC,
    output logic               TX_OUT,
    output logic               BUSY
);

    // The bit index only has to reach D_SIZE-1. A 1-bit word still gets a
    // 1-bit index so the vector width is never zero.
    localparam int IDX_W = (D_SIZE > 1) ? $clog2(D_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q,   state_d;
    logic [D_SIZE-1:0]  shift_q,   shift_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [PS_SIZE-1:0] ps_q,      ps_d;      // latched bit period (never 0)
    logic [PS_SIZE-1:0] cnt_q,     cnt_d;     // cycles left in current bit
    logic               par_en_q,  par_en_d;
    logic               par_bit_q, par_bit_d; // parity precomputed at capture
    logic               tx_q,      tx_d;
    logic               busy_q,    busy_d;

    logic [PS_SIZE-1:0] ps_in;
    logic               bit_end;
    logic               pop;

    // A zero prescale would never let the down-counter expire, so it is
    // treated as a one-cycle bit.
    assign ps_in   = (PRESCALE == '0) ? PS_SIZE'(1) : PRESCALE;
    assign bit_end = (cnt_q == '0);

    // Pop whenever we are free to take a word. "Free" means we are idle, or we
    // are in the last stop-bit cycle so the next frame can follow directly.
    assign pop   = !EMPTY && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    // Gate the pop while in reset so that a waiting word is not lost.
    assign R_INC = pop && !RST;

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        ps_d      = ps_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
            end

            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    cnt_d     = ps_q - PS_SIZE'(1);
                end else begin
                    cnt_d = cnt_q - PS_SIZE'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = ps_q - PS_SIZE'(1);
                    if (bit_idx_q == LAST_IDX) begin
                        // The index holds at LAST_IDX, so it never wraps here.
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - PS_SIZE'(1);
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    cnt_d   = ps_q - PS_SIZE'(1);
                end else begin
                    cnt_d = cnt_q - PS_SIZE'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    // Stay on the line only if a word is captured below.
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q - PS_SIZE'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Capture overrides the state-specific next values. Configuration is
        // latched here, so later input changes only affect later frames.
        if (pop) begin
            state_d   = START;
            shift_d   = RD_DATA;
            bit_idx_d = '0;
            ps_d      = ps_in;
            cnt_d     = ps_in - PS_SIZE'(1);
            par_en_d  = PAR_EN;
            par_bit_d = (^RD_DATA) ^ PAR_TYP;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            ps_q      <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            ps_q      <= ps_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter D_SIZE, default 8, data word width; matches FIFO RD_DATA width.
REQ-002 SHALL have parameter PS_SIZE, default 6, PRESCALE input width.
REQ-003 SHALL have port CLK  input  1  single operating clock (FIFO read-domain clock).
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port EMPTY  input  1  FIFO empty flag; 0 means RD_DATA holds a valid head word.
REQ-006 SHALL have port RD_DATA  input  D_SIZE  FIFO head word, first-word-fall-through, valid while EMPTY=0.
REQ-007 SHALL have port PAR_EN  input  1  1 = parity bit inserted after data.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port PRESCALE  input  PS_SIZE  CLK cycles per serial bit; 0 treated as 1.
REQ-010 SHALL have port R_INC  output  1  FIFO pop strobe, one CLK cycle per word.
REQ-011 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-012 SHALL have port BUSY  output  1  high while a frame is on the line.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE with EMPTY=0, SHALL, in the same cycle, assert R_INC, capture RD_DATA into shift register, latch PAR_EN/PAR_TYP/PRESCALE, and go to START on the next edge.
REQ-015 SHALL never assert R_INC while EMPTY=1; R_INC SHALL be exactly one cycle wide per popped word.
REQ-016 Config inputs SHALL affect only frames captured after they change; a frame in flight uses latched values.
REQ-017 Each bit (start, data, parity, stop) SHALL hold TX_OUT stable for exactly max(PRESCALE,1) CLK cycles, timed by a down-counter reloaded at each bit boundary.
REQ-018 START SHALL drive TX_OUT=0; DATA SHALL drive D_SIZE bits LSB first; PARITY SHALL drive XOR of the captured word (even) or its complement (odd); STOP SHALL drive TX_OUT=1.
REQ-019 DATA SHALL go to PARITY if latched PAR_EN=1, else directly to STOP; the bit index counter SHALL be ceil(log2(D_SIZE)) bits and SHALL NOT wrap mid-frame.
REQ-020 Frame length SHALL be (D_SIZE+2+PAR_EN) x max(PRESCALE,1) cycles from first TX_OUT=0 cycle to end of stop bit.
REQ-021 In the last cycle of STOP, if EMPTY=0, SHALL pop and capture the next word (as REQ-014) and go to START: back-to-back frames with no idle cycle; else go to IDLE.
REQ-022 TX_OUT and BUSY SHALL be registered outputs; TX_OUT first goes low the cycle after the capture cycle.
REQ-023 BUSY SHALL be 1 in START, DATA, PARITY, STOP and 0 in IDLE.
REQ-024 EMPTY rising while a frame is in flight SHALL NOT alter that frame.

Reset
REQ-025 RST=1 SHALL asynchronously force state IDLE, TX_OUT=1, BUSY=0, R_INC=0, all counters and shift register 0.
REQ-026 Reset mid-frame SHALL abort the frame; the already-popped word is dropped and SHALL NOT be re-read.
REQ-027 After RST deassertion, first capture SHALL occur no earlier than the first CLK edge with RST=0 and EMPTY=0.

Verification
REQ-028 EMPTY=0, RD_DATA=0xA5, PRESCALE=4, PAR_EN=0, then EMPTY=1 -> one R_INC pulse; TX_OUT = 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles); BUSY high 40 cycles.
REQ-029 RD_DATA=0xA5, PAR_EN=1, PAR_TYP=0 then PAR_TYP=1 (PRESCALE=2) -> parity bit 0 then 1; frame 22 cycles each.
REQ-030 Two words 0x01, 0x80 queued, PRESCALE=1, PAR_EN=0 -> two R_INC pulses 10 cycles apart; TX_OUT 0,1,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,1,1 with no idle gap.
REQ-031 EMPTY=1 held 100 cycles after reset -> R_INC=0, TX_OUT=1, BUSY=0 throughout.
REQ-032 RST pulsed during DATA bit 3 of 0xFF -> TX_OUT=1, BUSY=0 immediately (asynchronously); next frame starts with next FIFO word, not 0xFF.
REQ-033 PRESCALE=0, PAR_EN=0, RD_DATA=0x55 -> 10-cycle frame, 1 cycle per bit; PRESCALE changed to 8 mid-frame -> current frame unchanged.
